// File: rtl/spi_controller_pkg.sv
// Shared definitions for the SPI controller: FSM encodings, frame layout and
// the register map of the attached PWM peripheral.
package spi_controller_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_LEAD = 3'd1;
  localparam state_t ST_HIGH = 3'd2;
  localparam state_t ST_LOW  = 3'd3;
  localparam state_t ST_GAP  = 3'd4;

  localparam int FRAME_BITS = 16;
  localparam int RW_BIT     = 15;
  localparam int ADDR_MSB   = 14;
  localparam int ADDR_LSB   = 8;

  // Peripheral register map
  localparam logic [6:0] REG_OUT_EN   = 7'h00;
  localparam logic [6:0] REG_PWM_MODE = 7'h01;
  localparam logic [6:0] REG_PWM_CFG  = 7'h02;
  localparam logic [6:0] REG_PWM_AUX  = 7'h03;
  localparam logic [6:0] REG_DUTY     = 7'h04;

  function automatic logic [FRAME_BITS-1:0] pack_frame(input logic       rw,
                                                       input logic [6:0] addr,
                                                       input logic [7:0] wdata);
    logic [FRAME_BITS-1:0] f;
    f                    = '0;
    f[RW_BIT]            = rw;
    f[ADDR_MSB:ADDR_LSB] = addr;
    f[7:0]               = wdata;
    return f;
  endfunction

endpackage

// File: rtl/spi_controller.sv
// SPI mode-0 master issuing 16-bit {rw, addr, wdata} frames; returns the last
// eight CIPO bits of each frame. All pin outputs come straight from flops.
module spi_controller
  import spi_controller_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  output logic [7:0] resp_rdata,
  output logic       SCLK,
  output logic       COPI,
  output logic       nCS,
  input  logic       CIPO
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t                state;
  logic [7:0]            div_cnt;
  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-2:0] tx_sr;
  logic [7:0]            rx_sr;
  logic [FRAME_BITS-1:0] frame;
  logic                  accept;
  logic                  div_end;

  assign frame   = pack_frame(req_rw, req_addr, req_wdata);
  assign accept  = (state == ST_IDLE) && req_valid && req_ready;
  assign div_end = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    resp_valid <= 1'b0;
    if (rst) begin
      state      <= ST_IDLE;
      nCS        <= 1'b1;
      SCLK       <= 1'b0;
      COPI       <= 1'b0;
      req_ready  <= 1'b1;
      resp_rdata <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_LEAD;
            req_ready <= 1'b0;
            nCS       <= 1'b0;
            COPI      <= frame[RW_BIT];
            div_cnt   <= '0;
            bit_cnt   <= 4'd15;
          end
        end
        ST_LEAD: begin
          div_cnt <= div_end ? '0 : div_cnt + 8'd1;
          if (div_end) begin
            state <= ST_HIGH;
            SCLK  <= 1'b1;
          end
        end
        ST_HIGH: begin
          div_cnt <= div_end ? '0 : div_cnt + 8'd1;
          // COPI moves only on the falling SCLK edge, keeping it stable at each rise
          if (div_end) begin
            state <= ST_LOW;
            SCLK  <= 1'b0;
            COPI  <= tx_sr[FRAME_BITS-2];
          end
        end
        ST_LOW: begin
          div_cnt <= div_end ? '0 : div_cnt + 8'd1;
          if (div_end) begin
            if (bit_cnt == 4'd0) begin
              state      <= ST_GAP;
              nCS        <= 1'b1;
              COPI       <= 1'b0;
              resp_valid <= 1'b1;
              resp_rdata <= rx_sr;
            end else begin
              state   <= ST_HIGH;
              SCLK    <= 1'b1;
              bit_cnt <= bit_cnt - 4'd1;
            end
          end
        end
        ST_GAP: begin
          div_cnt <= div_end ? '0 : div_cnt + 8'd1;
          if (div_end) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          nCS       <= 1'b1;
          SCLK      <= 1'b0;
          COPI      <= 1'b0;
          req_ready <= 1'b1;
          div_cnt   <= '0;
          bit_cnt   <= '0;
        end
      endcase
    end
  end

  // Shift registers carry data only and need no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      tx_sr <= frame[FRAME_BITS-2:0];
    end else if (state == ST_HIGH && div_end) begin
      tx_sr <= {tx_sr[FRAME_BITS-3:0], 1'b0};
    end
    if (state == ST_HIGH && div_cnt == 8'd0) begin
      rx_sr <= {rx_sr[6:0], CIPO};
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller with a behavioural SPI peripheral that
// decodes frames, holds a small register file and answers reads on CIPO.
module tb_spi_controller;
  import spi_controller_pkg::*;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_rw = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       req_ready;
  logic       resp_valid;
  logic [7:0] resp_rdata;
  logic       SCLK;
  logic       COPI;
  logic       nCS;
  logic       CIPO;

  int n_checks = 0;
  int n_fail   = 0;

  spi_controller #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .SCLK      (SCLK),
    .COPI      (COPI),
    .nCS       (nCS),
    .CIPO      (CIPO)
  );

  initial forever #5 clk = ~clk;

  // Peripheral model: samples COPI on SCLK rise, presents read data after the address
  logic        ncs_q = 1'b1;
  logic        sclk_q = 1'b0;
  logic        copi_q = 1'b0;
  logic [15:0] pm_shift = '0;
  logic [15:0] last_frame = '0;
  logic [7:0]  pm_dout = '0;
  logic [7:0]  pregs [0:127];
  int          pm_rise = 0;

  always @(posedge clk) begin
    ncs_q  <= nCS;
    sclk_q <= SCLK;
    copi_q <= COPI;
    if (rst && !nCS) begin
      pm_rise <= 0;
    end
    if (nCS) begin
      if (!ncs_q) begin
        last_frame <= pm_shift;
        if (pm_rise == 16 && pm_shift[15]) pregs[pm_shift[14:8]] <= pm_shift[7:0];
      end
      pm_rise <= 0;
      CIPO    <= 1'b0;
    end else if (SCLK && !sclk_q) begin
      pm_shift <= {pm_shift[14:0], COPI};
      pm_rise  <= pm_rise + 1;
      if (pm_rise == 7) begin
        pm_dout <= pregs[{pm_shift[5:0], COPI}];
        CIPO    <= pregs[{pm_shift[5:0], COPI}][7];
      end else if (pm_rise >= 8 && pm_rise <= 14) begin
        CIPO <= pm_dout[14-pm_rise];
      end else begin
        CIPO <= 1'b0;
      end
    end
  end

  initial begin
    for (int i = 0; i < 128; i++) pregs[i] = 8'h00;
  end

  // Pin monitor: nCS run lengths, response pulses, COPI stability at SCLK rise
  int low_run = 0, high_run = 0, last_low = 0, last_high = 0;
  int resp_cnt = 0, copi_bad = 0;

  always @(posedge clk) begin
    if (!nCS) begin
      low_run <= low_run + 1;
      if (high_run != 0) last_high <= high_run;
      high_run <= 0;
    end else begin
      high_run <= high_run + 1;
      if (low_run != 0) last_low <= low_run;
      low_run <= 0;
    end
    if (resp_valid) resp_cnt <= resp_cnt + 1;
    if (!nCS && SCLK && !sclk_q && COPI !== copi_q) copi_bad <= copi_bad + 1;
  end

  task automatic issue(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                       input bit keep);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = addr;
    req_wdata = data;
    for (int i = 0; i < 2000; i++) begin
      if (req_ready) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: req_ready never observed high, required 1");
    end
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string name, output logic [7:0] data);
    bit seen;
    seen = 1'b0;
    data = 8'hxx;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1'b1;
        data = resp_rdata;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_resp_timeout: resp_valid never pulsed, required one pulse", name);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (nCS !== 1'b1) begin n_fail++; $display("FAIL reset_ncs: got %b want 1", nCS); end
    n_checks++;
    if (SCLK !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b want 0", SCLK); end
    n_checks++;
    if (COPI !== 1'b0) begin n_fail++; $display("FAIL reset_copi: got %b want 0", COPI); end
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_checks++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    n_checks++;
    if (resp_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h want 00", resp_rdata); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    logic [7:0] d;
    int r0;
    r0 = resp_cnt;
    issue(1'b1, REG_OUT_EN, 8'hF0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL write_busy_ready: got %b want 0", req_ready); end
    wait_resp("write", d);
    n_checks++;
    if (last_frame !== 16'h80F0) begin n_fail++; $display("FAIL write_copi_bits: got %h want 80f0", last_frame); end
    n_checks++;
    if (last_low !== 33*CLK_DIV) begin n_fail++; $display("FAIL write_ncs_low: got %0d want %0d", last_low, 33*CLK_DIV); end
    n_checks++;
    if (resp_cnt - r0 !== 1) begin n_fail++; $display("FAIL write_resp_pulses: got %0d want 1", resp_cnt - r0); end
    n_checks++;
    if (copi_bad !== 0) begin n_fail++; $display("FAIL write_copi_stable: got %0d changes want 0", copi_bad); end
    n_checks++;
    if (pregs[REG_OUT_EN] !== 8'hF0) begin n_fail++; $display("FAIL write_periph_reg0: got %h want f0", pregs[REG_OUT_EN]); end
  endtask

  task automatic test_end_to_end();
    logic [7:0] d;
    issue(1'b1, REG_DUTY, 8'h80, 1'b0);
    wait_resp("duty", d);
    n_checks++;
    if (pregs[REG_DUTY] !== 8'h80) begin n_fail++; $display("FAIL duty_reg: got %h want 80", pregs[REG_DUTY]); end
  endtask

  task automatic test_read();
    logic [7:0] d;
    issue(1'b1, REG_PWM_CFG, 8'hA5, 1'b0);
    wait_resp("preload", d);
    issue(1'b0, REG_PWM_CFG, 8'h00, 1'b0);
    wait_resp("read", d);
    n_checks++;
    if (d !== 8'hA5) begin n_fail++; $display("FAIL read_rdata: got %h want a5", d); end
    n_checks++;
    if (resp_rdata !== 8'hA5) begin n_fail++; $display("FAIL read_rdata_held: got %h want a5", resp_rdata); end
    n_checks++;
    if (pregs[REG_PWM_CFG] !== 8'hA5) begin n_fail++; $display("FAIL read_no_write: got %h want a5", pregs[REG_PWM_CFG]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    int r0;
    r0 = resp_cnt;
    issue(1'b1, REG_OUT_EN, 8'h11, 1'b1);
    // second request waits with req_valid high for the whole first frame
    issue(1'b1, REG_PWM_MODE, 8'h22, 1'b0);
    wait_resp("b2b", d);
    n_checks++;
    if (last_high !== CLK_DIV + 1) begin n_fail++; $display("FAIL b2b_ncs_gap: got %0d want %0d", last_high, CLK_DIV + 1); end
    n_checks++;
    if (resp_cnt - r0 !== 2) begin n_fail++; $display("FAIL b2b_resp_pulses: got %0d want 2", resp_cnt - r0); end
    n_checks++;
    if (pregs[REG_OUT_EN] !== 8'h11) begin n_fail++; $display("FAIL b2b_first_reg: got %h want 11", pregs[REG_OUT_EN]); end
    n_checks++;
    if (pregs[REG_PWM_MODE] !== 8'h22) begin n_fail++; $display("FAIL b2b_second_reg: got %h want 22", pregs[REG_PWM_MODE]); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    int r0;
    bit seen;
    seen = 1'b0;
    issue(1'b1, REG_PWM_AUX, 8'h3C, 1'b0);
    r0 = resp_cnt;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (pm_rise == 6) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL mid_sixth_rise: got %0d rises want 6", pm_rise); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (nCS !== 1'b1) begin n_fail++; $display("FAIL mid_ncs: got %b want 1", nCS); end
    n_checks++;
    if (SCLK !== 1'b0) begin n_fail++; $display("FAIL mid_sclk: got %b want 0", SCLK); end
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", req_ready); end
    n_checks++;
    if (resp_rdata !== 8'h00) begin n_fail++; $display("FAIL mid_rdata: got %h want 00", resp_rdata); end
    repeat (40) @(negedge clk);
    n_checks++;
    if (resp_cnt !== r0) begin n_fail++; $display("FAIL mid_no_resp: got %0d pulses want 0", resp_cnt - r0); end
    n_checks++;
    if (pregs[REG_PWM_AUX] !== 8'h00) begin n_fail++; $display("FAIL mid_no_write: got %h want 00", pregs[REG_PWM_AUX]); end
    issue(1'b0, REG_DUTY, 8'h00, 1'b0);
    wait_resp("after_reset", d);
    n_checks++;
    if (d !== 8'h80) begin n_fail++; $display("FAIL mid_recover_read: got %h want 80", d); end
    n_checks++;
    if (last_low !== 33*CLK_DIV) begin n_fail++; $display("FAIL mid_recover_ncs_low: got %0d want %0d", last_low, 33*CLK_DIV); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_end_to_end();
    test_read();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
